// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, the lock burst limit and the bus widths.
package datamem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [3:0] LOCK_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/datamem_arb_pick.sv
// Combinational winner selection for the two-port data-memory arbiter.
// Ports: req[1:0] requests, last = last granted port, force_en/force_port =
// pending post-release override, win[1:0] one-hot winner (0 if no request).
// Policy: DATAMEM_ARB_ROUND_ROBIN_EN defined -> contention grants ~last,
// otherwise contention grants port 0.
module datamem_arb_pick
    import datamem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_en,
    input  logic       force_port,
    output logic [1:0] win
);

    logic sel;

`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    assign sel = force_en ? force_port : ~last;
`else
    logic unused_last;
    assign unused_last = last;
    assign sel = force_en ? force_port : 1'b0;
`endif

    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = sel ? 2'b10 : 2'b01;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with lock bursts.
// Ports: clk, reset_n (async active-low); per port p: req_p, we_p, lock_p,
// addr_p, wdata_p in; gnt_p, rvalid_p, rdata_p out. Memory side: mem_address,
// mem_write_enable, mem_read_enable, mem_write_data out; mem_read_data in.
// Config macro: DATAMEM_ARB_ROUND_ROBIN_EN (round-robin vs fixed priority).
module datamem_arbiter
    import datamem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_0,
    input  logic              we_0,
    input  logic              lock_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic              lock_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, cnt_nxt, cnt_inc;
    logic       last;
    logic       force_en, force_en_nxt;
    logic       force_port, force_port_nxt;
    logic [1:0] req, lock, win, gnt_c, gnt_v;
    logic       own, other;
    logic       we_g;

    assign req  = {req_1, lock_1 & 1'b0 | req_1 & 1'b0 | req_0};
    assign lock = {lock_1, lock_0};

    datamem_arb_pick u_pick (
        .req        (req),
        .last       (last),
        .force_en   (force_en),
        .force_port (force_port),
        .win        (win)
    );

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = burst_cnt;
        cnt_inc        = burst_cnt;
        force_en_nxt   = force_en;
        force_port_nxt = force_port;
        gnt_c          = 2'b00;
        own            = (state == OWN1);
        other          = ~own;
        unique case (state)
            IDLE: begin
                gnt_c = win;
                if (|req) force_en_nxt = 1'b0;
                if (win[0] && lock_0) begin
                    state_nxt = OWN0;
                    cnt_nxt   = 4'd1;
                end else if (win[1] && lock_1) begin
                    state_nxt = OWN1;
                    cnt_nxt   = 4'd1;
                end else begin
                    cnt_nxt = 4'd0;
                end
            end
            OWN0, OWN1: begin
                if (!req[own]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    gnt_c[own] = 1'b1;
                    cnt_inc    = (burst_cnt == LOCK_MAX) ? LOCK_MAX
                                                         : burst_cnt + 4'd1;
                    cnt_nxt    = cnt_inc;
                    // Burst limit reached while the other port waits:
                    // release and hand it the next arbitration.
                    if (cnt_inc == LOCK_MAX && req[other]) begin
                        state_nxt      = IDLE;
                        cnt_nxt        = 4'd0;
                        force_en_nxt   = 1'b1;
                        force_port_nxt = other;
                    end else if (!lock[own]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // No access may start while reset is held, even from IDLE.
    assign gnt_v = reset_n ? gnt_c : 2'b00;
    assign gnt_0 = gnt_v[0];
    assign gnt_1 = gnt_v[1];

    assign we_g = (gnt_v[0] & we_0) | (gnt_v[1] & we_1);

    assign mem_write_enable = we_g;
    assign mem_read_enable  = (|gnt_v) & ~we_g;
    assign mem_address      = gnt_v[0] ? addr_0 :
                              gnt_v[1] ? addr_1 : '0;
    assign mem_write_data   = gnt_v[0] ? wdata_0 :
                              gnt_v[1] ? wdata_1 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last       <= 1'b1;
            force_en   <= 1'b0;
            force_port <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= cnt_nxt;
            force_en   <= force_en_nxt;
            force_port <= force_port_nxt;
            if (gnt_v[0]) begin
                last <= 1'b0;
            end else if (gnt_v[1]) begin
                last <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            rvalid_0 <= gnt_v[0] & ~we_0;
            rvalid_1 <= gnt_v[1] & ~we_1;
            if (gnt_v[0] && !we_0) rdata_0 <= mem_read_data;
            if (gnt_v[1] && !we_1) rdata_1 <= mem_read_data;
        end
    end

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 For each requester p in {0,1}, the module SHALL provide:
- req_p  in  1  access request
- we_p  in  1  1=write, 0=read
- lock_p  in  1  request to keep ownership
- addr_p  in  16  word address
- wdata_p  in  16  write data
- gnt_p  out  1  access performed this cycle
- rvalid_p  out  1  read data valid
- rdata_p  out  16  registered read data
REQ-003 The memory side SHALL be:
- mem_address  out  16
- mem_write_enable  out  1
- mem_read_enable  out  1
- mem_write_data  out  16
- mem_read_data  in  16  (combinational read data from the memory)
REQ-004 The memory's own reset SHALL be driven by the system, not by this block.

Function
REQ-005 At most one memory access SHALL occur per cycle; gnt_0 and gnt_1 SHALL never both be 1.
REQ-006 gnt_p SHALL be combinational in the cycle of grant, and the mem_* outputs SHALL carry the granted requester's we/addr/wdata in that same cycle.
REQ-007 With no grant, mem_write_enable, mem_read_enable, mem_address and mem_write_data SHALL be 0.
REQ-008 mem_read_enable SHALL equal gnt & ~we, and mem_write_enable SHALL equal gnt & we.
REQ-009 On a granted read, rdata_p SHALL capture mem_read_data at the next rising edge, and rvalid_p SHALL be 1 for exactly the following cycle (latency 1).
REQ-010 rdata_p SHALL hold its value until the next read by port p.
REQ-011 A granted write SHALL not assert rvalid_p.
REQ-012 The state machine SHALL have the states IDLE, OWN0 and OWN1, plus a 4-bit burst counter burst_cnt and a last-granted pointer last.
REQ-013 In IDLE with a single requester, that requester SHALL be granted.
REQ-014 In IDLE with both requesting, the winner SHALL be chosen by the arbitration policy (REQ-024/025).
REQ-015 In IDLE, if the winner has lock_p=1, the next state SHALL be OWNp with burst_cnt=1.
REQ-016 In OWNp, only port p SHALL be grantable: if req_p=1, then gnt_p=1 and burst_cnt increments.
REQ-017 OWNp SHALL return to IDLE after a cycle in which any of the following holds: req_p=0 (no grant in that cycle); lock_p=0 (the grant still occurs); or burst_cnt reached LOCK_MAX=8 while the other port was requesting.
REQ-018 At burst_cnt=LOCK_MAX with the other port idle, OWNp SHALL continue and burst_cnt SHALL saturate at LOCK_MAX.
REQ-019 After a forced release, the other port SHALL win the next IDLE arbitration regardless of policy.
REQ-020 last SHALL update to p on every gnt_p.
REQ-021 Address and data SHALL pass through unmodified: no width change, and no wrap or alignment check on the 16-bit addresses.

Reset
REQ-022 While reset_n=0 (asynchronous assertion), the block SHALL set state=IDLE, burst_cnt=0, last=1, rvalid_0=rvalid_1=0, rdata_0=rdata_1=0, and hold gnt_p and all mem_* enables at 0.
REQ-023 A read granted in the cycle reset asserts SHALL be discarded (no rvalid after release), and the first arbitration after release SHALL favour port 0.

Configuration
REQ-024 With the macro DATAMEM_ARB_ROUND_ROBIN_EN defined, IDLE contention SHALL grant the port not equal to last.
REQ-025 Without DATAMEM_ARB_ROUND_ROBIN_EN, IDLE contention SHALL always grant port 0 (fixed priority), except after a forced release (REQ-019).

Structure
REQ-026 The package datamem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), LOCK_MAX=8, ADDR_W=16 and DATA_W=16.
REQ-027 The combinational winner selection (req, last, force, policy) SHALL be a sub-module named datamem_arb_pick; the state machine, counter and read registers SHALL stay in datamem_arbiter.

Verification
REQ-028 Scenario, single read: port 0 reads addr 0x0000 after memory reset -> gnt_0 in cycle 0; rvalid_0=1 and rdata_0=0x4470 in cycle 1; rvalid_1 stays 0.
REQ-029 Scenario, contention: both ports write every cycle (port 0 0x0010 <- 0xAAAA, port 1 0x0011 <- 0xBBBB) -> with DATAMEM_ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it port 0 is granted every cycle.
REQ-030 Scenario, lock and starvation: port 1 holds lock_1=1 with continuous reads while port 0 requests -> exactly 8 consecutive gnt_1, then gnt_0 in the next cycle.
REQ-031 Scenario, lock drop: port 0 is locked for 3 grants and then drops lock_0 while keeping req_0 -> the 4th access is granted, state returns to IDLE, and port 1 contends in the next cycle.
REQ-032 Scenario, reset mid-burst: reset_n is pulled low asynchronously mid-cycle during an OWN1 read -> rvalid_1=0 immediately; after release the state is IDLE and the first contention grants port 0.
REQ-033 Scenario, write-then-read: port 0 writes 0x1234 to 0x00FF, then port 1 reads 0x00FF -> rdata_1=0x1234 with rvalid_1 one cycle after gnt_1.
